// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - framebuffer read port and VGA pin bundle for vga_scanout
interface vga_scanout_if;
  logic [18:0] ram_address;
  logic [1:0]  ram_read_data;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        frame_start;

  modport master (
    output ram_address,
    input  ram_read_data,
    output hsync,
    output vsync,
    output red,
    output green,
    output blue,
    output frame_start
  );

  modport slave (
    input  ram_address,
    output ram_read_data,
    input  hsync,
    input  vsync,
    input  red,
    input  green,
    input  blue,
    input  frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator reading a half-resolution 2-bit framebuffer
module vga_scanout #(
  parameter int          CLK_DIV      = 2,
  parameter int          H_VISIBLE    = 640,
  parameter int          H_FRONT      = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BACK       = 48,
  parameter int          V_VISIBLE    = 480,
  parameter int          V_FRONT      = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BACK       = 33,
  parameter logic        SYNC_ACTIVE  = 1'b0,
  parameter logic [11:0] COLOR_BG     = 12'h000,
  parameter logic [11:0] COLOR_P1     = 12'hF80,
  parameter logic [11:0] COLOR_P2     = 12'h0AF,
  parameter logic [11:0] COLOR_BORDER = 12'hFFF
) (
  input  logic          clock,
  input  logic          reset,
  vga_scanout_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SS     = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SE     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SS     = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SE     = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [18:0]   FB_STEP  = 19'(H_VISIBLE / 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          tick;
  logic [HW-1:0] h, h_next;
  logic [VW-1:0] v, v_next;
  logic [18:0]   row_base, row_base_next;
  logic [18:0]   addr_next;
  logic          active_next;
  logic          active0, hs0, vs0;
  logic          running;
  logic [11:0]   colour;
  logic [11:0]   rgb;
  logic [18:0]   ram_address_q;
  logic          hsync_q, vsync_q, frame_start_q;

  assign tick = (div == DIV_LAST);

  // Row base walks in steps of one framebuffer row every second screen line.
  always_comb begin
    h_next        = h;
    v_next        = v;
    row_base_next = row_base;
    if (h == H_LAST) begin
      h_next = '0;
      if (v == V_LAST) begin
        v_next        = '0;
        row_base_next = '0;
      end else begin
        v_next = v + VW'(1);
        if (!v_next[0] && (v_next < V_VIS)) begin
          row_base_next = row_base + FB_STEP;
        end
      end
    end else begin
      h_next = h + HW'(1);
    end
  end

  always_comb begin
    active_next = (h_next < H_VIS) && (v_next < V_VIS);
    addr_next   = active_next ? (row_base_next + 19'(h_next >> 1)) : '0;
    active0     = (h < H_VIS) && (v < V_VIS);
    hs0         = ((h >= H_SS) && (h < H_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs0         = ((v >= V_SS) && (v < V_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_comb begin
    colour = COLOR_BG;
    case (vga.ram_read_data)
      2'b00:   colour = COLOR_BG;
      2'b01:   colour = COLOR_P1;
      2'b10:   colour = COLOR_P2;
      2'b11:   colour = COLOR_BORDER;
      default: colour = COLOR_BG;
    endcase
  end

  // RAM data for the current position arrives at least one clock before the next tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div           <= '0;
      h             <= '0;
      v             <= '0;
      row_base      <= '0;
      ram_address_q <= '0;
      rgb           <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      frame_start_q <= 1'b0;
      running       <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      div           <= tick ? '0 : div + DW'(1);
      if (tick) begin
        h             <= h_next;
        v             <= v_next;
        row_base      <= row_base_next;
        ram_address_q <= addr_next;
        rgb           <= active0 ? colour : 12'h000;
        hsync_q       <= hs0;
        vsync_q       <= vs0;
        running       <= 1'b1;
        frame_start_q <= !running || ((h_next == '0) && (v_next == '0));
      end
    end
  end

  assign vga.ram_address = ram_address_q;
  assign vga.red         = rgb[11:8];
  assign vga.green       = rgb[7:4];
  assign vga.blue        = rgb[3:0];
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;
endmodule
